// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three requesters, the memory and mem_arbiter.
// The arbiter uses "slave"; the requester/memory side uses "master".
interface mem_arbiter_if;
  logic        vid_req;
  logic [22:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic        aux_req;
  logic        aux_we;
  logic [22:0] aux_addr;
  logic [7:0]  aux_din;
  logic        aux_ack;
  logic [7:0]  aux_dout;
  logic [22:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [15:0] mem_din;
  logic        mem_ready;
  logic        busy;
  logic        timeout_err;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
    input  aux_req, aux_we, aux_addr, aux_din, mem_din, mem_ready,
    output vid_ack, vid_data, cpu_ack, cpu_dout, aux_ack, aux_dout,
    output mem_addr, mem_rd, mem_wr, mem_dout, busy, timeout_err
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
    output aux_req, aux_we, aux_addr, aux_din, mem_din, mem_ready,
    input  vid_ack, vid_data, cpu_ack, cpu_dout, aux_ack, aux_dout,
    input  mem_addr, mem_rd, mem_wr, mem_dout, busy, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Three-way memory arbiter (video > cpu > aux, with aux anti-starvation)
// running one IDLE/CMD/WAIT/ACK transaction at a time.
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CMD = 2'd1, ST_WAIT = 2'd2, ST_ACK = 2'd3} state_t;
  typedef enum logic [1:0] {OWN_VID = 2'd0, OWN_CPU = 2'd1, OWN_AUX = 2'd2} owner_t;

  state_t      state_r, state_nxt;
  owner_t      owner_r, gnt_owner_s;
  logic [22:0] addr_r, gnt_addr_s;
  logic        gnt_we_s, grant_s, done_s, expire_s;
  logic [7:0]  gnt_din_s, rd_byte_s;
  logic [15:0] rd_word_s;
  logic [SW-1:0] starve_r;
  logic [TW-1:0] wait_cnt_r;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= ST_IDLE;
    else          state_r <= state_nxt;
  end

  // next state, arbitration decision and read-data selection
  always_comb begin
    state_nxt   = state_r;
    grant_s     = 1'b0;
    gnt_owner_s = owner_r;
    gnt_addr_s  = 23'h0;
    gnt_we_s    = 1'b0;
    gnt_din_s   = 8'h00;
    done_s      = 1'b0;
    expire_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.vid_req) begin
          grant_s = 1'b1; gnt_owner_s = OWN_VID; gnt_addr_s = bus.vid_addr;
        end else if (bus.aux_req && (starve_r >= SW'(STARVE_MAX))) begin
          grant_s = 1'b1; gnt_owner_s = OWN_AUX; gnt_addr_s = bus.aux_addr;
          gnt_we_s = bus.aux_we; gnt_din_s = bus.aux_din;
        end else if (bus.cpu_req) begin
          grant_s = 1'b1; gnt_owner_s = OWN_CPU; gnt_addr_s = bus.cpu_addr;
          gnt_we_s = bus.cpu_we; gnt_din_s = bus.cpu_din;
        end else if (bus.aux_req) begin
          grant_s = 1'b1; gnt_owner_s = OWN_AUX; gnt_addr_s = bus.aux_addr;
          gnt_we_s = bus.aux_we; gnt_din_s = bus.aux_din;
        end else begin
          grant_s = 1'b0;
        end
        if (grant_s) state_nxt = ST_CMD;
        else         state_nxt = ST_IDLE;
      end
      ST_CMD:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.mem_ready) begin
          done_s = 1'b1; state_nxt = ST_ACK;
        end else if (wait_cnt_r == TW'(TIMEOUT - 1)) begin
          done_s = 1'b1; expire_s = 1'b1; state_nxt = ST_ACK;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (expire_s) rd_word_s = 16'hFFFF;
    else          rd_word_s = bus.mem_din;
    if (addr_r[0]) rd_byte_s = rd_word_s[15:8];
    else           rd_byte_s = rd_word_s[7:0];
  end

  // transaction latches, counters and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_r         <= OWN_VID;
      addr_r          <= 23'h0;
      starve_r        <= '0;
      wait_cnt_r      <= '0;
      bus.mem_addr    <= 23'h0;
      bus.mem_dout    <= 8'h00;
      bus.mem_rd      <= 1'b0;
      bus.mem_wr      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.vid_ack     <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.aux_ack     <= 1'b0;
      bus.vid_data    <= 16'h0000;
      bus.cpu_dout    <= 8'h00;
      bus.aux_dout    <= 8'h00;
    end else begin
      bus.mem_rd      <= 1'b0;
      bus.mem_wr      <= 1'b0;
      bus.vid_ack     <= 1'b0;
      bus.cpu_ack     <= 1'b0;
      bus.aux_ack     <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.busy        <= (state_nxt != ST_IDLE);
      if (grant_s) begin
        owner_r      <= gnt_owner_s;
        addr_r       <= gnt_addr_s;
        bus.mem_addr <= gnt_addr_s;
        bus.mem_dout <= gnt_din_s;
        bus.mem_wr   <= gnt_we_s;
        bus.mem_rd   <= ~gnt_we_s;
      end
      if ((state_r == ST_WAIT) && !done_s) wait_cnt_r <= wait_cnt_r + TW'(1);
      else                                 wait_cnt_r <= '0;
      // starvation only accumulates while aux is actually waiting
      if (!bus.aux_req)                                  starve_r <= '0;
      else if (grant_s && (gnt_owner_s == OWN_AUX))      starve_r <= '0;
      else if (grant_s && (gnt_owner_s == OWN_CPU) && (starve_r < SW'(STARVE_MAX)))
                                                         starve_r <= starve_r + SW'(1);
      else                                               starve_r <= starve_r;
      if (done_s) begin
        bus.timeout_err <= expire_s;
        case (owner_r)
          OWN_VID: begin bus.vid_ack <= 1'b1; bus.vid_data <= rd_word_s; end
          OWN_CPU: begin bus.cpu_ack <= 1'b1; bus.cpu_dout <= rd_byte_s; end
          OWN_AUX: begin bus.aux_ack <= 1'b1; bus.aux_dout <= rd_byte_s; end
          default: bus.timeout_err <= expire_s;
        endcase
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive CPU grants after which a pending aux request takes priority over CPU.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before forced completion.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  video fetch request; level, held until ack.
- vid_addr  in  23  video word address.
- vid_ack  out  1  one-cycle completion pulse.
- vid_data  out  16  fetched word.
- cpu_req, cpu_we  in  1 each  CPU request; write enable.
- cpu_addr  in  23  CPU byte address.
- cpu_din  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_dout  out  8  CPU read byte.
- aux_req, aux_we, aux_addr(23), aux_din(8), aux_ack, aux_dout(8): same meanings for the expansion/DMA requester.
- mem_addr  out  23  memory address.
- mem_rd, mem_wr  out  1 each  one-cycle command strobes.
- mem_dout  out  8  write data.
- mem_din  in  16  read word.
- mem_ready  in  1  memory completion.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on forced completion.

Function
REQ-004 SHALL implement states IDLE, CMD, WAIT, ACK.
REQ-005 IDLE SHALL sample requests on each edge; if any eligible req is high, SHALL latch owner, addr, we and din, and go to CMD.
REQ-006 Fixed priority SHALL be vid > cpu > aux, with one exception: if the starve counter is >= STARVE_MAX and aux_req is high, aux SHALL win over cpu. vid always wins.
REQ-007 Starve counter: SHALL increment (saturating at STARVE_MAX) on a CPU grant made while aux_req is high; SHALL clear on an aux grant or when aux_req is low.
REQ-008 CMD SHALL last exactly one cycle, drive mem_addr from latched addr and mem_dout from latched din, and pulse mem_wr if we else mem_rd; video requests are always reads. Next state: WAIT.
REQ-009 mem_ready SHALL be ignored in CMD and sampled only in WAIT.
REQ-010 mem_addr SHALL hold the latched address through CMD and WAIT.
REQ-011 WAIT with mem_ready=1 SHALL register read data and go to ACK.
REQ-012 WAIT SHALL count cycles; on reaching TIMEOUT without mem_ready, SHALL go to ACK with read data 8'hFF/16'hFFFF and pulse timeout_err.
REQ-013 ACK SHALL last one cycle and pulse only the owner's ack. Next state: IDLE.
REQ-014 In the ACK cycle the owner's req SHALL be ignored; the requester must drop req by the next edge.
REQ-015 Read byte selection: cpu_dout/aux_dout = addr[0] ? mem_din[15:8] : mem_din[7:0]; vid_data = mem_din[15:0].
REQ-016 Data outputs SHALL hold the last value until the next completion for that requester.
REQ-017 If a requester drops req after the grant, the transaction SHALL still complete and ack SHALL still pulse.
REQ-018 Simultaneous requests: the loser SHALL stay pending and be considered at the next IDLE; no request is lost while its req stays high.
REQ-019 Minimum turnaround SHALL be 4 cycles per transaction (IDLE, CMD, WAIT, ACK).

Reset
REQ-020 On reset_n low, asynchronously: state IDLE; all acks, mem_rd, mem_wr, busy and timeout_err 0; mem_addr, mem_dout, vid_data, cpu_dout and aux_dout 0; starve and timeout counters 0; in-flight transaction dropped without ack.
REQ-021 After reset_n rises, the first grant SHALL occur no earlier than the first clk edge with reset_n high.

Verification
REQ-022 cpu read, cpu_addr=0x000101, mem_din=0xAB12, mem_ready 2 cycles after CMD -> single mem_rd pulse with mem_addr=0x000101; cpu_ack 1 cycle; cpu_dout=0xAB.
REQ-023 vid_req and cpu_req both high at the same edge -> video served first (vid_data=mem_din); cpu served next; each ack exactly once.
REQ-024 cpu_req and aux_req held continuously, mem_ready immediate -> grant order C,C,C,C,A,C,C,C,C,A (STARVE_MAX=4).
REQ-025 mem_ready never asserted, cpu read -> after 255 WAIT cycles cpu_ack=1, cpu_dout=0xFF, timeout_err pulses once; busy returns 0.
REQ-026 reset_n pulled low during WAIT of an aux write -> all outputs 0 immediately; no aux_ack; a new cpu_req after release is served normally.
